// File: rtl/adder_run_seq_pkg.sv
// Shared FSM encoding, carry-in mode constants and default widths for the
// LFSR-fed adder run sequencer.
package adder_run_seq_pkg;

    localparam int DEF_DATA_W = 12;
    localparam int DEF_CNT_W  = 8;
    localparam int DEF_ACC_W  = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [1:0] CIN_ZERO = 2'b00;
    localparam logic [1:0] CIN_ONE  = 2'b01;
    localparam logic [1:0] CIN_ALT  = 2'b10;

    // Carry-in for the first sample; the alternating mode also starts at 0.
    function automatic logic first_cin(input logic [1:0] mode);
        return (mode == CIN_ONE);
    endfunction

endpackage

// File: rtl/adder_run_acc.sv
// Checksum accumulator and carry-out counter for one sequencer run.
module adder_run_acc
    import adder_run_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              clear_i,
    input  logic              en_i,
    input  logic [DATA_W:0]   sample_i,
    output logic [ACC_W-1:0]  acc_o,
    output logic [CNT_W-1:0]  carry_cnt_o
);

    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] carry_q;

    // The sample's top bit is the adder carry-out; the sum wraps at ACC_W.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_q   <= '0;
            carry_q <= '0;
        end else if (clear_i) begin
            acc_q   <= '0;
            carry_q <= '0;
        end else if (en_i) begin
            acc_q <= acc_q + ACC_W'(sample_i);
            if (sample_i[DATA_W]) begin
                carry_q <= carry_q + CNT_W'(1);
            end
        end
    end

    assign acc_o       = acc_q;
    assign carry_cnt_o = carry_q;

endmodule

// File: rtl/adder_run_seq.sv
// Run controller: latches a configuration, loads both LFSR seeds, drives the
// adder carry-in and checksums N samples of {c_out,sum}.
module adder_run_seq
    import adder_run_seq_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_seed_a,
    input  logic [DATA_W-1:0] cfg_seed_b,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic [1:0]        cfg_cin_mode,
    output logic              lfsr_load_n,
    output logic [DATA_W-1:0] seed_a,
    output logic [DATA_W-1:0] seed_b,
    output logic              cin,
    input  logic [DATA_W-1:0] sum,
    input  logic              c_out,
    output logic              sample_valid,
    output logic [DATA_W:0]   sample_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ACC_W-1:0]  acc,
    output logic [CNT_W-1:0]  carry_cnt
);

    state_e            state_q;
    logic [DATA_W-1:0] seed_a_q;
    logic [DATA_W-1:0] seed_b_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  smp_cnt_q;
    logic [1:0]        mode_q;
    logic              load_n_q;
    logic              cin_q;
    logic              valid_q;
    logic              busy_q;
    logic              done_q;
    logic              aborted_q;

    logic              acc_clear;
    logic              last_sample;

    assign acc_clear   = (state_q == ST_IDLE) && start;
    assign last_sample = ((smp_cnt_q + CNT_W'(1)) == count_q);

    // Outputs are registered alongside the state so each one reflects the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            seed_a_q  <= '0;
            seed_b_q  <= '0;
            count_q   <= '0;
            mode_q    <= CIN_ZERO;
            smp_cnt_q <= '0;
            load_n_q  <= 1'b0;
            cin_q     <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        seed_a_q  <= cfg_seed_a;
                        seed_b_q  <= cfg_seed_b;
                        count_q   <= cfg_count;
                        mode_q    <= cfg_cin_mode;
                        smp_cnt_q <= '0;
                        cin_q     <= first_cin(cfg_cin_mode);
                        busy_q    <= 1'b1;
                        state_q   <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                        aborted_q <= 1'b1;
                        cin_q     <= 1'b0;
                    end else if (count_q != '0) begin
                        state_q  <= ST_RUN;
                        load_n_q <= 1'b1;
                        valid_q  <= 1'b1;
                    end else begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cin_q   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    smp_cnt_q <= smp_cnt_q + CNT_W'(1);
                    if (mode_q == CIN_ALT) begin
                        cin_q <= ~cin_q;
                    end
                    // Abort takes priority over a coincident final sample.
                    if (abort || last_sample) begin
                        state_q   <= abort ? ST_IDLE : ST_DONE;
                        aborted_q <= abort;
                        done_q    <= !abort;
                        load_n_q  <= 1'b0;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        cin_q     <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    adder_run_acc #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) u_acc (
        .clk         (clk),
        .resetn      (resetn),
        .clear_i     (acc_clear),
        .en_i        (valid_q),
        .sample_i    ({c_out, sum}),
        .acc_o       (acc),
        .carry_cnt_o (carry_cnt)
    );

    assign lfsr_load_n  = load_n_q;
    assign seed_a       = seed_a_q;
    assign seed_b       = seed_b_q;
    assign cin          = cin_q;
    assign sample_valid = valid_q;
    assign sample_data  = valid_q ? {c_out, sum} : '0;
    assign busy         = busy_q;
    assign done         = done_q;
    assign aborted      = aborted_q;

endmodule

// File: tb/tb_adder_run_seq.sv
// Scoreboard bench for adder_run_seq: a default build and a narrow-accumulator
// build share stimulus, and a monitor checks every sample/done/abort event.
module tb_adder_run_seq;

    localparam int DW = 12;
    localparam int CW = 8;

    localparam int EV_SAMPLE = 0;
    localparam int EV_DONE   = 1;
    localparam int EV_ABORT  = 2;

    typedef struct {
        int          kind;
        int          cyc;
        logic [12:0] data;
        logic        cin;
        longint      acc;
        longint      accW;
        int          ccnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic          resetn;
    logic          start;
    logic          abort;
    logic [DW-1:0] cfgSeedA;
    logic [DW-1:0] cfgSeedB;
    logic [CW-1:0] cfgCount;
    logic [1:0]    cfgMode;
    logic [DW-1:0] sum;
    logic          cOut;

    logic          loadN,   wLoadN;
    logic [DW-1:0] seedA,   wSeedA;
    logic [DW-1:0] seedB,   wSeedB;
    logic          cin,     wCin;
    logic          sValid,  wValid;
    logic [DW:0]   sData,   wData;
    logic          busy,    wBusy;
    logic          done,    wDone;
    logic          aborted, wAborted;
    logic [23:0]   acc;
    logic [12:0]   wAcc;
    logic [CW-1:0] carryCnt, wCarryCnt;

    adder_run_seq dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cfg_seed_a(cfgSeedA), .cfg_seed_b(cfgSeedB), .cfg_count(cfgCount),
        .cfg_cin_mode(cfgMode), .lfsr_load_n(loadN), .seed_a(seedA), .seed_b(seedB),
        .cin(cin), .sum(sum), .c_out(cOut), .sample_valid(sValid), .sample_data(sData),
        .busy(busy), .done(done), .aborted(aborted), .acc(acc), .carry_cnt(carryCnt)
    );

    adder_run_seq #(.ACC_W(13)) dutW (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .cfg_seed_a(cfgSeedA), .cfg_seed_b(cfgSeedB), .cfg_count(cfgCount),
        .cfg_cin_mode(cfgMode), .lfsr_load_n(wLoadN), .seed_a(wSeedA), .seed_b(wSeedB),
        .cin(wCin), .sum(sum), .c_out(cOut), .sample_valid(wValid), .sample_data(wData),
        .busy(wBusy), .done(wDone), .aborted(wAborted), .acc(wAcc), .carry_cnt(wCarryCnt)
    );

    int vectors = 0;
    int miscompares = 0;
    exp_t sbQ[$];
    logic [12:0] smp[$];

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
        end
    endtask

    function automatic logic expCin(input logic [1:0] mode, input int k);
        if (mode == 2'b01) return 1'b1;
        if (mode == 2'b10) return k[0];
        return 1'b0;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fillRandom(input int n);
        smp.delete();
        for (int k = 0; k < n; k++) smp.push_back(13'($urandom));
    endtask

    task automatic randomCfg();
        cfgSeedA = DW'($urandom);
        cfgSeedB = DW'($urandom);
        cfgCount = CW'($urandom);
        cfgMode  = 2'($urandom);
    endtask

    task automatic checkReset(input string name);
        checkOutput({name, "_ctrl"}, {loadN, cin, sValid, busy, done, aborted}, 0);
        checkOutput({name, "_seeds"}, {seedA, seedB}, 0);
        checkOutput({name, "_acc"}, acc, 0);
        checkOutput({name, "_carry_cnt"}, carryCnt, 0);
        checkOutput({name, "_sample_data"}, sData, 0);
        checkOutput({name, "_w_ctrl"}, {wLoadN, wCin, wValid, wBusy, wDone, wAborted}, 0);
        checkOutput({name, "_w_acc"}, {wAcc, wCarryCnt, wSeedA, wSeedB}, 0);
    endtask

    // Monitor: every DUT event must match the head of the scoreboard queue.
    exp_t me;
    always @(negedge clk) begin
        if (resetn) begin
            if (sValid || done || aborted) begin
                checkOutput("done_aborted_exclusive", done & aborted, 0);
                if (sbQ.size() == 0) begin
                    checkOutput("unexpected_event", {sValid, done, aborted}, 0);
                end else begin
                    me = sbQ.pop_front();
                    checkOutput("event_cycle", cycle, me.cyc);
                    checkOutput("event_kind", sValid ? EV_SAMPLE : (done ? EV_DONE : EV_ABORT), me.kind);
                    if (sValid) begin
                        checkOutput("sample_data", sData, me.data);
                        checkOutput("sample_cin", cin, me.cin);
                        checkOutput("run_load_n_busy", {loadN, busy}, 2'b11);
                        checkOutput("w_sample", {wValid, wCin, wData}, {1'b1, me.cin, me.data});
                    end else begin
                        checkOutput("end_acc", acc, me.acc);
                        checkOutput("end_carry_cnt", carryCnt, me.ccnt);
                        checkOutput("end_load_n_busy", {loadN, busy}, 0);
                        checkOutput("w_end_acc", wAcc, me.accW);
                        checkOutput("w_end_flags", {wDone, wAborted, wCarryCnt},
                                    {me.kind == EV_DONE, me.kind == EV_ABORT, 8'(me.ccnt)});
                    end
                end
            end else begin
                checkOutput("sample_data_idle", sData, 0);
            end
        end
    end

    // One complete run; samples come from smp[], expectations are queued up front.
    task automatic applyStimulus(input logic [11:0] sa, input logic [11:0] sb, input int n,
                                 input logic [1:0] mode, input int abortAt, input bit abortLoad,
                                 input bit abortWithStart, input bit startWhileBusy,
                                 input int resetAt);
        int     c0;
        int     taken;
        longint total;
        int     carries;
        bit     aborting;
        exp_t   e;
        aborting = abortLoad || (abortAt >= 0);
        taken    = abortLoad ? 0 : ((abortAt >= 0) ? abortAt + 1 : n);
        step();
        c0 = cycle;
        start = 1'b1;
        abort = abortWithStart;
        cfgSeedA = sa;
        cfgSeedB = sb;
        cfgCount = CW'(n);
        cfgMode  = mode;
        {cOut, sum} = 13'($urandom);
        total   = 0;
        carries = 0;
        for (int k = 0; k < taken; k++) begin
            e.kind = EV_SAMPLE; e.cyc = c0 + 2 + k; e.data = smp[k];
            e.cin = expCin(mode, k); e.acc = 0; e.accW = 0; e.ccnt = 0;
            sbQ.push_back(e);
            total   += longint'(smp[k]);
            carries += int'(smp[k][12]);
        end
        e.kind = aborting ? EV_ABORT : EV_DONE;
        e.cyc  = c0 + 2 + taken;
        e.data = 0;
        e.cin  = 0;
        e.acc  = total % (64'd1 << 24);
        e.accW = total % (64'd1 << 13);
        e.ccnt = carries;
        sbQ.push_back(e);

        step();
        start = 1'b0;
        abort = abortLoad;
        randomCfg();
        {cOut, sum} = 13'($urandom);
        checkOutput("load_load_n_busy", {loadN, busy, wLoadN, wBusy}, 4'b0101);
        checkOutput("load_cleared", {acc, carryCnt}, 0);
        checkOutput("load_w_cleared", {wAcc, wCarryCnt}, 0);
        checkOutput("load_seeds", {seedA, seedB, wSeedA, wSeedB}, {sa, sb, sa, sb});
        checkOutput("load_cin", cin, expCin(mode, 0));

        for (int k = 0; k < taken; k++) begin
            step();
            {cOut, sum} = smp[k];
            abort = (k == abortAt);
            start = startWhileBusy && (k == 0);
            if (start) randomCfg();
            if (k == resetAt) begin
                #2;
                resetn = 1'b0;
                #1;
                checkReset("midrun_reset");
                sbQ.delete();
                step();
                resetn = 1'b1;
                start = 1'b0;
                abort = 1'b0;
                return;
            end
        end

        step();
        start = 1'b0;
        abort = 1'b0;
        {cOut, sum} = 13'($urandom);
        step();
        step();
        checkOutput("events_outstanding", sbQ.size(), 0);
        checkOutput("held_acc", acc, e.acc);
        checkOutput("held_w_acc", wAcc, e.accW);
        checkOutput("held_carry_cnt", carryCnt, e.ccnt);
        checkOutput("idle_load_n_busy", {loadN, busy}, 0);
    endtask

    initial begin
        int n;
        int abortAt;
        bit abortLoad;
        resetn = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        cfgSeedA = '0;
        cfgSeedB = '0;
        cfgCount = '0;
        cfgMode  = '0;
        sum  = '0;
        cOut = 1'b0;
        #1;
        resetn = 1'b0;
        step();
        step();
        checkReset("por");
        resetn = 1'b1;
        step();

        smp = '{13'h001, 13'h002, 13'h003, 13'h004};
        applyStimulus(12'h001, 12'h009, 4, 2'b00, -1, 1'b0, 1'b0, 1'b0, -1);

        smp = '{13'h1FFF, 13'h0001, 13'h1000};
        applyStimulus(12'h0A5, 12'h35C, 3, 2'b01, -1, 1'b0, 1'b0, 1'b0, -1);

        fillRandom(5);
        applyStimulus(12'h123, 12'h456, 5, 2'b10, -1, 1'b0, 1'b0, 1'b0, -1);

        smp.delete();
        applyStimulus(12'hFFF, 12'h800, 0, 2'b01, -1, 1'b0, 1'b0, 1'b0, -1);

        fillRandom(10);
        applyStimulus(12'h00F, 12'hF00, 10, 2'b10, 2, 1'b0, 1'b0, 1'b1, -1);

        fillRandom(4);
        applyStimulus(12'h111, 12'h222, 4, 2'b00, -1, 1'b1, 1'b0, 1'b0, -1);

        fillRandom(2);
        applyStimulus(12'h333, 12'h444, 2, 2'b01, -1, 1'b0, 1'b1, 1'b0, -1);

        fillRandom(10);
        applyStimulus(12'h555, 12'h666, 10, 2'b10, -1, 1'b0, 1'b0, 1'b0, 3);

        smp = '{13'h1000, 13'h1000, 13'h1000};
        applyStimulus(12'h777, 12'h888, 3, 2'b11, -1, 1'b0, 1'b0, 1'b0, -1);

        for (int r = 0; r < 12; r++) begin
            n = int'($urandom_range(0, 14));
            abortAt = -1;
            abortLoad = 1'b0;
            if (n > 0 && $urandom_range(0, 3) == 0) abortAt = int'($urandom_range(0, n - 1));
            else if ($urandom_range(0, 7) == 0) abortLoad = 1'b1;
            fillRandom(n);
            applyStimulus(12'($urandom), 12'($urandom), n, 2'($urandom), abortAt, abortLoad,
                          1'($urandom), 1'($urandom), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adder_run_seq.md
Name: adder_run_seq

Overview:
- Sequencer for the LFSR-fed 12-bit adder datapath.
- Latches a run configuration on `start`, then loads the seeds into both LFSRs via their active-low load/reset input.
- Drives the adder carry-in according to a mode, samples `{c_out,sum}` for N cycles, accumulates a checksum and a carry count, then reports completion.
- Replaces hand-sequenced seed/reset/carry stimulus around the adder with one self-checking run controller.

Parameters:
- DATA_W, 12, adder operand and sum width.
- CNT_W, 8, width of sample count and carry counter.
- ACC_W, 24, checksum accumulator width.

Ports:
- clk  in  1  clock, all state updates on posedge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle run request; honoured only in IDLE.
- abort  in  1  terminates the run; honoured in LOAD and RUN.
- cfg_seed_a  in  DATA_W  seed for LFSR A, latched on accepted start.
- cfg_seed_b  in  DATA_W  seed for LFSR B, latched on accepted start.
- cfg_count  in  CNT_W  number of samples N, latched on accepted start.
- cfg_cin_mode  in  2  00 cin=0, 01 cin=1, 10 alternate starting at 0, 11 same as 00.
- lfsr_load_n  out  1  active-low seed load to both LFSR resetn inputs.
- seed_a  out  DATA_W  latched seed A.
- seed_b  out  DATA_W  latched seed B.
- cin  out  1  adder carry-in.
- sum  in  DATA_W  adder sum.
- c_out  in  1  adder carry-out.
- sample_valid  out  1  high in each RUN cycle a sample is taken.
- sample_data  out  DATA_W+1  `{c_out,sum}` sampled this cycle, combinational pass-through qualified by sample_valid.
- busy  out  1  high in LOAD and RUN.
- done  out  1  one-cycle pulse on normal completion.
- aborted  out  1  one-cycle pulse on abort.
- acc  out  ACC_W  checksum.
- carry_cnt  out  CNT_W  count of samples with c_out=1.

Behaviour:
- Reset values (asynchronous, resetn low):
  - state=IDLE; lfsr_load_n=0; seeds=0; cin=0.
  - sample_valid=0; busy=0; done=0; aborted=0.
  - acc=0; carry_cnt=0; internal sample counter=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - lfsr_load_n=0, so LFSRs are held at their seeds.
  - start=1 latches seeds, count and mode; clears acc, carry_cnt and the sample counter; goes to LOAD.
  - acc and carry_cnt hold the last results until the next accepted start.
- LOAD: exactly one cycle.
  - lfsr_load_n=0, cin set to its first value.
  - Next state is RUN if N>0, else DONE.
- RUN:
  - lfsr_load_n=1, sample_valid=1.
  - Each cycle: acc <= acc + zero-extended `{c_out,sum}`, wrapping modulo 2^ACC_W.
  - carry_cnt increments when c_out=1; it cannot overflow, since it counts at most N ≤ 2^CNT_W−1 samples.
  - Sample counter increments each cycle; after the Nth sample the next state is DONE.
  - Mode 10: cin toggles after every sample, so sample k uses cin = k mod 2.
- DONE: one cycle.
  - done=1, lfsr_load_n=0; next state is IDLE.
  - acc and carry_cnt are final from this cycle onward.
- Latency: start accepted at edge t → LOAD cycle t+1 → first sample cycle t+2 → done in cycle t+2+N.
- Abort in LOAD or RUN:
  - Next state IDLE; aborted=1 for one cycle; lfsr_load_n=0; done is not asserted.
  - A sample in the abort cycle is still accumulated; partial acc/carry_cnt are held.
- Simultaneous abort and last sample: abort wins (aborted pulse, no done).
- start outside IDLE: ignored, with no effect on config or counters.
- start and abort together in IDLE: start accepted, abort ignored.
- cfg_* are sampled only on accepted start; later changes have no effect during the run.
- resetn asserted mid-run: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit).
  - cin mode constants CIN_ZERO, CIN_ONE, CIN_ALT.
  - Default widths DATA_W=12, CNT_W=8, ACC_W=24.
- One natural sub-module: adder_run_acc, holding the accumulator plus carry counter with clear/enable inputs.
- FSM and config latches stay in the top.

Test Plan:
- Directed run:
  - Stimulus: seeds 0x001/0x009, N=4, mode 00; bench drives sums 1,2,3,4 with c_out=0.
  - Response: LOAD one cycle after start; sample_valid for exactly 4 cycles; done one cycle after the last sample; acc=10, carry_cnt=0.
- Carry handling:
  - Stimulus: N=3, mode 01; inputs `{c_out,sum}` = {1,0xFFF},{0,0x001},{1,0x000}.
  - Response: cin=1 in all RUN cycles; acc=0x1FFF+0x001+0x1000=0x3000; carry_cnt=2.
- Alternate carry and zero count:
  - Stimulus: mode 10, N=5.
  - Response: cin sequence 0,1,0,1,0.
  - Stimulus: N=0.
  - Response: done exactly two cycles after start; acc=0; no sample_valid.
- Abort:
  - Stimulus: N=10, abort in the 3rd RUN cycle.
  - Response: aborted pulse; no done; 3 samples accumulated; lfsr_load_n low the next cycle; a start issued while busy before the abort is ignored.
- Reset mid-run:
  - Stimulus: drop resetn asynchronously during RUN.
  - Response: all outputs return to reset values immediately; a new start after release runs normally.
- Wrap:
  - Stimulus: ACC_W=13 build, N=3, each sample 0x1000.
  - Response: acc=0x1000 (wrapped), carry_cnt=3.
